// File: rtl/timer_incr_req.sv
// ============================================================================
// timer_incr_req
// ----------------------------------------------------------------------------
// Increment-request generator for the TIME1/3/4/5/6 counters. Three scaler
// phase levels arrive asynchronously to clk_sys. Each one is synchronised,
// its rising edges are turned into sticky per-counter requests, and those
// requests are presented to the counter priority chain. The chain hands back
// one-cycle grants that retire individual requests.
//
// If a new edge arrives while its request is still outstanding, that
// increment has been lost. The matching sticky overrun flag records this.
//
// Build option:
//   OVERRUN_CNT_EN  - adds ovf_cnt, a saturating 8-bit count of overrun
//                     events. When the macro is undefined the port and its
//                     logic do not exist.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   F10A     in   1  scaler stage 10 phase A (async) -> T1, T3, T5
//   F10B     in   1  scaler stage 10 phase B (async) -> T4
//   F06B     in   1  scaler stage 6 phase B (async)  -> T6
//   T6ON     in   1  TIME6 enable (sync)
//   gnt      in   1  one-cycle grant pulse
//   gnt_id   in   3  granted index: 1=T1 2=T3 3=T4 4=T5 5=T6
//   ovf_clr  in   1  synchronous clear of overrun flags (and ovf_cnt)
//   req      out  1  any request pending
//   req_id   out  3  highest-priority pending index, 0 if none
//   pend     out  5  pending flags: bit0=T1 bit1=T3 bit2=T4 bit3=T5 bit4=T6
//   ovf      out  5  sticky overrun flags, same bit order as pend
//   ovf_cnt  out  8  saturating overrun event count (OVERRUN_CNT_EN only)
// ============================================================================
module timer_incr_req (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       F10A,
    input  logic       F10B,
    input  logic       F06B,
    input  logic       T6ON,
    input  logic       gnt,
    input  logic [2:0] gnt_id,
    input  logic       ovf_clr,
    output logic       req,
    output logic [2:0] req_id,
    output logic [4:0] pend,
    output logic [4:0] ovf
`ifdef OVERRUN_CNT_EN
    ,
    output logic [7:0] ovf_cnt
`endif
);

    // Bit positions within the synchroniser vectors.
    localparam int SRC_F10A = 0;
    localparam int SRC_F10B = 1;
    localparam int SRC_F06B = 2;

    // Bit positions within pend / ovf.
    localparam int P_T1 = 0;
    localparam int P_T3 = 1;
    localparam int P_T4 = 2;
    localparam int P_T5 = 3;
    localparam int P_T6 = 4;

    logic [2:0] raw_in;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] prev;
    logic [2:0] rise_q;
    logic       sync_vld1;
    logic       sync_vld2;
    logic       primed;

    logic [4:0] set_v;
    logic [4:0] clr_v;
    logic [4:0] ovr_v;
    logic [4:0] pend_nxt;
    logic [4:0] ovf_nxt;

    assign raw_in = {F06B, F10B, F10A};

    // ------------------------------------------------------------------------
    // Synchroniser, edge detector and priming.
    //
    // sync_vld1/sync_vld2 follow the data through the two synchroniser flops
    // to mark when sync2 first holds a real post-reset sample. That sample is
    // loaded into prev, and only after that is primed raised. As a result, a
    // level that was already high at reset is absorbed as the baseline and is
    // not seen as an edge.
    //
    // The detected edge is registered once more in rise_q. A rise sampled at
    // edge N therefore updates pend at edge N+3.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            prev      <= '0;
            rise_q    <= '0;
            sync_vld1 <= 1'b0;
            sync_vld2 <= 1'b0;
            primed    <= 1'b0;
        end else begin
            sync1     <= raw_in;
            sync2     <= sync1;
            prev      <= sync2;
            sync_vld1 <= 1'b1;
            sync_vld2 <= sync_vld1;
            primed    <= sync_vld2;
            rise_q    <= primed ? (sync2 & ~prev) : 3'b000;
        end
    end

    // ------------------------------------------------------------------------
    // Request set vector. One F10A edge feeds three counters at once. The T6
    // request is qualified by its enable on the cycle the edge lands.
    // ------------------------------------------------------------------------
    always_comb begin
        set_v       = '0;
        set_v[P_T1] = rise_q[SRC_F10A];
        set_v[P_T3] = rise_q[SRC_F10A];
        set_v[P_T5] = rise_q[SRC_F10A];
        set_v[P_T4] = rise_q[SRC_F10B];
        set_v[P_T6] = rise_q[SRC_F06B] & T6ON;
    end

    // ------------------------------------------------------------------------
    // Grant decode. Only the named bit is retired, and only if it is actually
    // pending. Out-of-range or idle indices decode to nothing.
    // ------------------------------------------------------------------------
    always_comb begin
        clr_v = '0;
        if (gnt) begin
            case (gnt_id)
                3'd1:    clr_v[P_T1] = 1'b1;
                3'd2:    clr_v[P_T3] = 1'b1;
                3'd3:    clr_v[P_T4] = 1'b1;
                3'd4:    clr_v[P_T5] = 1'b1;
                3'd5:    clr_v[P_T6] = 1'b1;
                default: clr_v       = '0;
            endcase
        end
        clr_v = clr_v & pend;
    end

    // ------------------------------------------------------------------------
    // Next-state for pend and ovf.
    //
    // When a new edge arrives in the same cycle as a grant for that bit, the
    // grant is consumed and the new edge takes its place. pend stays high and
    // no increment is lost, so this is not counted as an overrun.
    //
    // Disabling TIME6 drops any outstanding T6 request. Its overrun history
    // is kept.
    //
    // A fresh overrun wins over ovf_clr for that bit.
    // ------------------------------------------------------------------------
    always_comb begin
        ovr_v          = set_v & pend & ~clr_v;
        pend_nxt       = set_v | (pend & ~clr_v);
        pend_nxt[P_T6] = pend_nxt[P_T6] & T6ON;
        ovf_nxt        = ovr_v | (ovf_clr ? 5'b00000 : ovf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            ovf  <= '0;
        end else begin
            pend <= pend_nxt;
            ovf  <= ovf_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Request outputs. Fixed priority: T1 > T3 > T4 > T5 > T6.
    // ------------------------------------------------------------------------
    assign req = |pend;

    always_comb begin
        req_id = 3'd0;
        if (pend[P_T1]) begin
            req_id = 3'd1;
        end else if (pend[P_T3]) begin
            req_id = 3'd2;
        end else if (pend[P_T4]) begin
            req_id = 3'd3;
        end else if (pend[P_T5]) begin
            req_id = 3'd4;
        end else if (pend[P_T6]) begin
            req_id = 3'd5;
        end
    end

`ifdef OVERRUN_CNT_EN
    // ------------------------------------------------------------------------
    // Overrun event counter. A single F10A edge can overrun three requests at
    // once, so the per-cycle increment is a popcount of ovr_v. When ovf_clr
    // coincides with new overruns, the counter restarts from this cycle's
    // events rather than from zero.
    // ------------------------------------------------------------------------
    logic [2:0] ovr_num;
    logic [7:0] cnt_base;
    logic [8:0] cnt_sum;

    always_comb begin
        ovr_num = 3'd0;
        for (int i = 0; i < 5; i++) begin
            ovr_num = ovr_num + {2'b00, ovr_v[i]};
        end
        cnt_base = ovf_clr ? 8'd0 : ovf_cnt;
        cnt_sum  = {1'b0, cnt_base} + {6'b000000, ovr_num};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= 8'd0;
        end else begin
            ovf_cnt <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
        end
    end
`endif

endmodule

// File: tb/tb_timer_incr_req.sv
// ============================================================================
// tb_timer_incr_req
// ----------------------------------------------------------------------------
// Bench for timer_incr_req. The reference model works at the level of raw
// input samples. A rise is a 0->1 step between two consecutive post-reset
// samples, and it is applied to the request flags three clocks later. Grants,
// enables and clears act on the request flags as whole-bit rules.
// Directed scenarios come first, followed by a randomized run.
// ============================================================================
module tb_timer_incr_req;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       F10A = 1'b0;
    logic       F10B = 1'b0;
    logic       F06B = 1'b0;
    logic       T6ON = 1'b0;
    logic       gnt = 1'b0;
    logic [2:0] gnt_id = 3'd0;
    logic       ovf_clr = 1'b0;
    logic       req;
    logic [2:0] req_id;
    logic [4:0] pend;
    logic [4:0] ovf;
`ifdef OVERRUN_CNT_EN
    logic [7:0] ovf_cnt;
`endif

    timer_incr_req dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .F10A    (F10A),
        .F10B    (F10B),
        .F06B    (F06B),
        .T6ON    (T6ON),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .ovf_clr (ovf_clr),
        .req     (req),
        .req_id  (req_id),
        .pend    (pend),
        .ovf     (ovf)
`ifdef OVERRUN_CNT_EN
        ,
        .ovf_cnt (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    logic [4:0] m_pend = '0;
    logic [4:0] m_ovf  = '0;
    int         m_cnt  = 0;
    int         m_k    = 0;
    logic [2:0] m_prev_raw = '0;
    logic [2:0] m_riseq[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pend     = '0;
        m_ovf      = '0;
        m_cnt      = 0;
        m_k        = 0;
        m_prev_raw = '0;
        m_riseq.delete();
    endtask

    // Advance the model by one rising clock edge, using the inputs that the
    // DUT sampled at that edge.
    task automatic model_step();
        logic [2:0] raw;
        logic [2:0] rise;
        logic [2:0] ap;
        logic [4:0] setv;
        logic [4:0] np;
        logic [4:0] no;
        int         g;
        int         n;
        bit         clr;
        bit         ovr;
        if (!rst_n) return;
        m_k++;
        raw        = {F06B, F10B, F10A};
        rise       = (m_k >= 2) ? (raw & ~m_prev_raw) : 3'b000;
        m_prev_raw = raw;
        m_riseq.push_back(rise);
        ap = 3'b000;
        if (m_riseq.size() > 3) ap = m_riseq.pop_front();
        setv = {ap[2] & T6ON, ap[0], ap[1], ap[0], ap[0]};
        g = (gnt && gnt_id >= 3'd1 && gnt_id <= 3'd5) ? int'(gnt_id) - 1 : -1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            clr   = (g == i) && m_pend[i];
            ovr   = setv[i] && m_pend[i] && !clr;
            n     = n + (ovr ? 1 : 0);
            np[i] = setv[i] || (m_pend[i] && !clr);
            no[i] = ovr || (m_ovf[i] && !ovf_clr);
        end
        if (!T6ON) np[4] = 1'b0;
        m_cnt  = (ovf_clr ? 0 : m_cnt) + n;
        if (m_cnt > 255) m_cnt = 255;
        m_pend = np;
        m_ovf  = no;
    endtask

    task automatic compare_all();
        int id;
        id = 0;
        for (int i = 4; i >= 0; i--) if (m_pend[i]) id = i + 1;
        check_val("pend", pend, m_pend);
        check_val("ovf", ovf, m_ovf);
        check_val("req", req, |m_pend);
        check_val("req_id", req_id, id);
`ifdef OVERRUN_CNT_EN
        check_val("ovf_cnt", ovf_cnt, m_cnt);
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("rst_pend", pend, 0);
        check_val("rst_req", req, 0);
        check_val("rst_req_id", req_id, 0);
        repeat (n) cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int idx;
        // F10A held high through reset must not produce a request.
        F10A = 1'b1;
        #2;
        apply_reset(3);
        repeat (10) cycle();
        check_val("held_high_no_req", pend, 0);

        // First true rise sets T1/T3/T5 exactly three clocks after sampling.
        F10A = 1'b0;
        repeat (4) cycle();
        F10A = 1'b1;
        repeat (3) cycle();
        check_val("pend_before_n3", pend, 0);
        cycle();
        check_val("pend_at_n3", pend, 5'b01011);
        check_val("req_id_t1", req_id, 1);

        // Grant walk: req_id 1 -> 2 -> 4 -> 0.
        gnt = 1'b1; gnt_id = 3'd1; cycle();
        check_val("req_id_after_g1", req_id, 2);
        gnt_id = 3'd2; cycle();
        check_val("req_id_after_g2", req_id, 4);
        check_val("req_before_last", req, 1);
        gnt_id = 3'd4; cycle();
        check_val("req_id_after_g4", req_id, 0);
        check_val("req_after_g4", req, 0);
        gnt = 1'b0; gnt_id = 3'd0;

        // T4 overrun, then clear.
        F10B = 1'b1;
        repeat (4) cycle();
        check_val("t4_pend", pend, 5'b00100);
        F10B = 1'b0;
        repeat (3) cycle();
        F10B = 1'b1;
        repeat (4) cycle();
        check_val("t4_still_pend", pend[2], 1);
        check_val("t4_ovf", ovf, 5'b00100);
        ovf_clr = 1'b1; cycle(); ovf_clr = 1'b0;
        check_val("ovf_cleared", ovf, 0);

        // Grant coinciding with a new T4 edge: no overrun.
        F10B = 1'b0;
        repeat (3) cycle();
        F10B = 1'b1;
        repeat (3) cycle();
        gnt = 1'b1; gnt_id = 3'd3; cycle();
        gnt = 1'b0; gnt_id = 3'd0;
        check_val("t4_coincide_pend", pend, 5'b00100);
        check_val("t4_coincide_ovf", ovf, 0);

        // T6 enable gating.
        T6ON = 1'b0;
        repeat (12) begin F06B = ~F06B; cycle(); cycle(); end
        check_val("t6_off_pend", pend[4], 0);
        F06B = 1'b0; T6ON = 1'b1;
        repeat (4) cycle();
        F06B = 1'b1;
        repeat (4) cycle();
        check_val("t6_on_pend", pend[4], 1);
        T6ON = 1'b0; cycle();
        check_val("t6_drop_pend", pend[4], 0);

        // Mid-operation reset discards pending requests.
        check_val("pre_reset_req", req, 1);
        apply_reset(2);
        repeat (6) cycle();
        check_val("post_reset_req", req, 0);

        // Randomized run.
        T6ON = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) apply_reset(2);
            if ($urandom_range(5) == 0) F10A = ~F10A;
            if ($urandom_range(5) == 0) F10B = ~F10B;
            if ($urandom_range(5) == 0) F06B = ~F06B;
            if ($urandom_range(49) == 0) T6ON = ~T6ON;
            ovf_clr = ($urandom_range(19) == 0);
            gnt     = ($urandom_range(2) == 0);
            if (m_pend != 5'b0 && $urandom_range(1) == 0) begin
                idx = $urandom_range(4);
                for (int j = 0; j < 5; j++) begin
                    if (!m_pend[idx]) idx = (idx + 1) % 5;
                end
                gnt_id = 3'(idx + 1);
            end else begin
                gnt_id = 3'($urandom_range(7));
            end
            cycle();
        end
        gnt = 1'b0; gnt_id = 3'd0; ovf_clr = 1'b0;

`ifdef OVERRUN_CNT_EN
        // Drive enough T6 overruns to saturate the counter, then clear it.
        T6ON = 1'b1;
        repeat (5) cycle();
        ovf_clr = 1'b1; cycle(); ovf_clr = 1'b0;
        repeat (620) begin F06B = ~F06B; cycle(); end
        repeat (5) cycle();
        check_val("ovf_cnt_sat", ovf_cnt, 255);
        ovf_clr = 1'b1; cycle(); ovf_clr = 1'b0;
        check_val("ovf_cnt_clr", ovf_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
